// File: rtl/amoa_pkg.sv
`default_nettype none
// amoa_pkg: adder constants, the frame-result record and a width helper,
// shared by the adder wrapper, the operand feeder and the sum accumulator.
package amoa_pkg;

  localparam int SUM_W = 11;
  localparam int LAT   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int ACC_LEN_DEF = 16;
  localparam int ACC_W_DEF   = SUM_W + clog2(ACC_LEN_DEF);

  typedef struct packed {
    logic [ACC_W_DEF-1:0] data;
    logic [7:0]           id;
  } acc_entry_t;

endpackage
`default_nettype wire

// File: rtl/amoa_sync_fifo.sv
`default_nettype none
// amoa_sync_fifo: synchronous FIFO, output taken straight from storage so a
// push becomes visible one cycle later; pushes when full and pops when empty are dropped.
module amoa_sync_fifo
  import amoa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && (level != FULL);
  assign do_pop   = pop && (level != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + (AW + 1)'(1);
      else if (!do_push && do_pop) level <= level - (AW + 1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/amoa_sum_accum.sv
`default_nettype none
// amoa_sum_accum: collects ACC_LEN adder sums per frame into a result FIFO and
// grants launch credit so a frame never starts without a free result slot.
module amoa_sum_accum
  import amoa_pkg::*;
#(
  parameter int ACC_LEN    = 16,
  parameter int ACC_W      = SUM_W + clog2(ACC_LEN),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic [SUM_W-1:0]            sum_in,
  output logic [ACC_W-1:0]            acc_data,
  output logic [7:0]                  acc_id,
  output logic                        acc_valid,
  input  logic                        acc_ready,
  output logic [clog2(FIFO_DEPTH):0]  fifo_lvl
);

  localparam int CW = (ACC_LEN > 1) ? clog2(ACC_LEN) : 1;
  localparam int LW = clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

  logic             launch;
  logic             sample;
  logic             last_sum;
  logic             push;
  logic             frame_start;
  logic [LAT-1:0]   vpipe;
  logic [CW-1:0]    scnt;
  logic [CW-1:0]    lcnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [7:0]       id;
  logic [LW-1:0]    pend;
  logic [ACC_W+7:0] fifo_dout;

  assign launch      = op_valid & op_ready;
  assign sample      = vpipe[LAT-1];
  assign last_sum    = (scnt == LAST);
  assign push        = sample & last_sum;
  assign frame_start = launch & (lcnt == '0);
  assign acc_next    = acc + ACC_W'(sum_in);
  assign acc_valid   = (fifo_lvl != '0);

  // A frame reserves its result slot at its first launch; later launches ride on it.
  assign op_ready = (lcnt != '0) | ((fifo_lvl + pend) < LW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      scnt  <= '0;
      lcnt  <= '0;
      acc   <= '0;
      id    <= '0;
      pend  <= '0;
    end else begin
      vpipe <= LAT'({vpipe, launch});
      if (launch) lcnt <= (lcnt == LAST) ? '0 : lcnt + CW'(1);
      if (sample) begin
        if (last_sum) begin
          acc  <= '0;
          scnt <= '0;
          id   <= id + 8'd1;
        end else begin
          acc  <= acc_next;
          scnt <= scnt + CW'(1);
        end
      end
      if (frame_start && !push)      pend <= pend + LW'(1);
      else if (!frame_start && push) pend <= pend - LW'(1);
    end
  end

  amoa_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ACC_W + 8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({acc_next, id}),
    .pop       (acc_valid & acc_ready),
    .pop_data  (fifo_dout),
    .level     (fifo_lvl)
  );

  assign {acc_data, acc_id} = fifo_dout;

endmodule
`default_nettype wire
